// File: rtl/systolic_ctrl.sv
// systolic_ctrl: job sequencer for the weight-stationary systolic array.
// Loads weight rows, streams skewed activations, captures result rows.
module systolic_ctrl #(
  parameter int ARRAY_SIZE  = 2,
  parameter int DATA_WIDTH  = 4,
  parameter int OUT_LATENCY = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [ARRAY_SIZE*ARRAY_SIZE*DATA_WIDTH-1:0] w_mat,
  input  logic [ARRAY_SIZE*ARRAY_SIZE*DATA_WIDTH-1:0] a_mat,
  output logic busy,
  output logic done,
  output logic arr_load,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] arr_weights,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] arr_activations,
  input  logic [ARRAY_SIZE*DATA_WIDTH*DATA_WIDTH-1:0] arr_output_row,
  output logic res_valid,
  output logic [ARRAY_SIZE*DATA_WIDTH*DATA_WIDTH-1:0] res_row,
  output logic [((ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1)-1:0] res_idx
);

  localparam int N  = ARRAY_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int RW = N * DW;
  localparam int CW = $clog2(OUT_LATENCY + N + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CW-1:0] LOAD_END = CW'(N - 1);
  localparam logic [CW-1:0] CAP_BEG  = CW'(OUT_LATENCY);
  localparam logic [CW-1:0] RUN_END  = CW'(OUT_LATENCY + N - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, GAP, RUN, DONE
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [N*N*DW-1:0] w_lat, a_lat;
  logic            capture;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CW'(1);
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        if (cnt == LOAD_END) begin
          state_nx = GAP;
          cnt_nx   = '0;
        end
      end
      GAP: begin
        state_nx = RUN;
        cnt_nx   = '0;
      end
      RUN: begin
        if (cnt == RUN_END) begin
          state_nx = DONE;
          cnt_nx   = '0;
        end
      end
      DONE: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign capture = (state == RUN) && (cnt >= CAP_BEG);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_lat     <= '0;
      a_lat     <= '0;
      res_valid <= 1'b0;
      res_row   <= '0;
      res_idx   <= '0;
    end else begin
      if (state == IDLE && start) begin
        w_lat <= w_mat;
        a_lat <= a_mat;
      end
      res_valid <= capture;
      if (capture) begin
        res_row <= arr_output_row;
        res_idx <= IW'(cnt - CAP_BEG);
      end
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign arr_load = (state == LOAD);

  // Weights go last row first; activation lane k lags lane 0 by k cycles.
  always_comb begin
    arr_weights     = '0;
    arr_activations = '0;
    if (state == LOAD)
      arr_weights = w_lat[(N - 1 - int'(cnt)) * RW +: RW];
    if (state == RUN) begin
      for (int k = 0; k < N; k++) begin
        if (int'(cnt) >= k && int'(cnt) - k <= N - 1)
          arr_activations[k*DW +: DW] =
            a_lat[((int'(cnt) - k) * N + k) * DW +: DW];
      end
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: directed jobs on a 2x2 and a 4x4 sequencer,
// captured rows checked against a scoreboard of driven array outputs.
module tb_systolic_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start_a;
  logic [15:0] w_a, a_a;
  logic        busy_a, done_a, load_a, rv_a;
  logic [7:0]  wts_a, act_a;
  logic [31:0] out_a, rrow_a;
  logic [0:0]  ridx_a;

  logic         start_b;
  logic [127:0] w_b, a_b;
  logic         busy_b, done_b, load_b, rv_b;
  logic [31:0]  wts_b, act_b;
  logic [255:0] out_b, rrow_b;
  logic [1:0]   ridx_b;

  systolic_ctrl dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .w_mat(w_a), .a_mat(a_a),
    .busy(busy_a), .done(done_a), .arr_load(load_a),
    .arr_weights(wts_a), .arr_activations(act_a),
    .arr_output_row(out_a),
    .res_valid(rv_a), .res_row(rrow_a), .res_idx(ridx_a)
  );

  systolic_ctrl #(
    .ARRAY_SIZE(4), .DATA_WIDTH(8), .OUT_LATENCY(5)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .w_mat(w_b), .a_mat(a_b),
    .busy(busy_b), .done(done_b), .arr_load(load_b),
    .arr_weights(wts_b), .arr_activations(act_b),
    .arr_output_row(out_b),
    .res_valid(rv_b), .res_row(rrow_b), .res_idx(ridx_b)
  );

  typedef struct {
    int           idx;
    logic [255:0] row;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic         o_busy, o_done, o_load, o_rv;
  logic [255:0] o_wts, o_act, o_row;
  int           o_idx;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap(input int inst);
    if (inst == 0) begin
      o_busy = busy_a; o_done = done_a; o_load = load_a; o_rv = rv_a;
      o_wts = 256'(wts_a); o_act = 256'(act_a);
      o_row = 256'(rrow_a); o_idx = int'(ridx_a);
    end else begin
      o_busy = busy_b; o_done = done_b; o_load = load_b; o_rv = rv_b;
      o_wts = 256'(wts_b); o_act = 256'(act_b);
      o_row = rrow_b; o_idx = int'(ridx_b);
    end
  endtask

  task automatic drive(input int inst, input logic s,
                       input logic [127:0] w, input logic [127:0] a);
    if (inst == 0) begin
      start_a = s; w_a = w[15:0]; a_a = a[15:0];
    end else begin
      start_b = s; w_b = w; a_b = a;
    end
  endtask

  task automatic set_out(input int inst, input logic [255:0] r);
    if (inst == 0) out_a = r[31:0];
    else out_b = r;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rnd256();
    return {rnd128(), rnd128()};
  endfunction

  function automatic logic [255:0] elem(input logic [127:0] m,
                                        input int idx, input int dw);
    logic [127:0] s, mk;
    mk = (128'd1 << dw) - 128'd1;
    s  = (m >> (idx * dw)) & mk;
    return 256'(s);
  endfunction

  task automatic do_abort(input int inst);
    reset = 1'b0;
    #1;
    snap(inst);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_load", o_load, 0);
    chk("rst_weights", o_wts, 0);
    chk("rst_acts", o_act, 0);
    chk("rst_valid", o_rv, 0);
    chk("rst_row", o_row, 0);
    chk("rst_idx", o_idx, 0);
    sbq.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      snap(inst);
      chk("post_rst_busy", o_busy, 0);
      chk("post_rst_done", o_done, 0);
    end
  endtask

  // mode 0: single start pulse; 1: extra start pulses mid-job;
  // 2: start left high so the next job follows right after.
  task automatic run_job(input int inst, input logic [127:0] w,
                         input logic [127:0] a, input int mode,
                         input int abort_at, input bit fixed);
    int n, dw, ol, last, t, nrv, nbusy;
    logic [255:0] ew, ea, rmask, r;
    logic [127:0] wm;
    exp_t e;
    n  = inst ? 4 : 2;
    dw = inst ? 8 : 4;
    ol = inst ? 5 : 3;
    last  = 2 * n + ol + 2;
    rmask = (256'd1 << (n * dw * dw)) - 256'd1;
    wm    = (128'd1 << (n * dw)) - 128'd1;
    nrv   = 0;
    nbusy = 0;
    drive(inst, 1'b1, w, a);
    @(posedge clk);
    #1 drive(inst, mode == 2, ~w, ~a);
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      if (c == abort_at) begin
        do_abort(inst);
        return;
      end
      snap(inst);
      t  = c - (n + 1);
      ew = '0;
      if (c < n) ew = 256'((w >> ((n - 1 - c) * n * dw)) & wm);
      ea = '0;
      if (t >= 0 && t < ol + n)
        for (int rr = 0; rr < n; rr++)
          for (int k = 0; k < n; k++)
            if (rr + k == t) ea |= elem(a, rr * n + k, dw) << (k * dw);
      chk("busy", o_busy, c < last);
      chk("done", o_done, c == last - 1);
      chk("arr_load", o_load, c < n);
      chk("arr_weights", o_wts, ew);
      chk("arr_activations", o_act, ea);
      chk("res_valid", o_rv, (t - 1 >= ol) && (t - 1 <= ol + n - 1));
      nbusy += int'(o_busy);
      nrv   += int'(o_rv);
      if (o_rv) begin
        chk("sb_pending", sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("res_idx", o_idx, e.idx);
          chk("res_row", o_row, e.row);
        end
      end
      if (t >= ol && t <= ol + n - 1) begin
        if (fixed) r = (t == ol) ? 256'h0007_0005 : 256'h000F_000B;
        else r = rnd256() & rmask;
        sbq.push_back('{t - ol, r});
      end else begin
        r = rnd256() & rmask;
      end
      set_out(inst, r);
      if (mode == 1)
        drive(inst, (c == 0) || (c == n + 2), rnd128(), rnd128());
    end
    chk("busy_cycles", nbusy, last);
    chk("valid_cycles", nrv, n);
    chk("sb_drained", sbq.size(), 0);
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, '0);
    out_a = '0;
    out_b = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      snap(i);
      chk("init_busy", o_busy, 0);
      chk("init_done", o_done, 0);
      chk("init_load", o_load, 0);
      chk("init_weights", o_wts, 0);
      chk("init_acts", o_act, 0);
      chk("init_valid", o_rv, 0);
      chk("init_row", o_row, 0);
    end
    reset = 1'b1;
    @(negedge clk);

    run_job(0, 128'h4321, 128'h4321, 0, -1, 1'b1);
    run_job(0, rnd128(), rnd128(), 1, -1, 1'b0);
    run_job(0, rnd128(), rnd128(), 2, -1, 1'b0);
    run_job(0, rnd128(), rnd128(), 0, -1, 1'b0);
    run_job(0, rnd128(), rnd128(), 0, 7, 1'b0);
    run_job(0, 128'h4321, 128'h4321, 0, -1, 1'b1);
    run_job(1, rnd128(), rnd128(), 0, -1, 1'b0);
    run_job(1, rnd128(), rnd128(), 1, -1, 1'b0);
    run_job(1, rnd128(), rnd128(), 2, -1, 1'b0);
    run_job(1, rnd128(), rnd128(), 0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
